frame_sequencer: RTL and testbench

- Per-frame scheduler for the vertex stage of the spinning-triangle pipeline.
- During vertical blanking it computes the next rotation angle and launches one vertex-setup job on the vertex shader with a start/done handshake.
- When the job completes it pulses a commit, so the rasterizer and fragment shader only see a new angle between frames (tear-free).
- Sits between signal_480p (x/y timing) and vert_shader / the cos, bz and cz angle ROMs.

---
 rtl/frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame angle scheduler for the vertex stage.
// During vertical blanking it computes the next rotation angle, runs one
// vertex-setup job on vert_shader (vs_start/vs_done) and then pulses commit,
// so downstream stages only ever see a new angle between frames.
// Optional build macro FRAME_SEQ_OVERRUN_EN: a job still running at the start
// of active video is abandoned and counted on overrun_count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// WAIT_VBL  | idle; on frame_end decide whether this frame advances
// ADVANCE   | compute angle_next from angle, dir and STEP (wrapping)
// START     | vs_start pulse to vert_shader
// WAIT_DONE | wait for vs_done (or abandon at start of active video)
// COMMIT    | angle <= angle_next, commit pulse
module frame_sequencer #(
   parameter int ANGLE_MAX = 359,
   parameter int STEP      = 1,
   parameter int FRAME_DIV = 1,
   parameter int V_ACTIVE  = 480
) (
   input  logic        clk_pix,
   input  logic        rst,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        run,
   input  logic        step,
   input  logic        dir,
   output logic [8:0]  angle_next,
   output logic [8:0]  angle,
   output logic        vs_start,
   input  logic        vs_done,
   output logic        commit,
   output logic        busy,
   output logic [15:0] frame_count
`ifdef FRAME_SEQ_OVERRUN_EN
   ,
   output logic [7:0]  overrun_count
`endif
);

   localparam int              DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [9:0]      STEP_W   = 10'(STEP);
   localparam logic [9:0]      MAX_W    = 10'(ANGLE_MAX);
   localparam logic [9:0]      MOD_W    = 10'(ANGLE_MAX + 1);

   typedef enum logic [2:0] {
      WAIT_VBL,
      ADVANCE,
      START,
      WAIT_DONE,
      COMMIT
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [DIV_W-1:0] divider;
   logic [DIV_W-1:0] divider_nx;
   logic             step_pending;
   logic             frame_end;
   logic [9:0]       angle_ext;
   logic [9:0]       angle_inc;
   logic [8:0]       angle_calc;
`ifdef FRAME_SEQ_OVERRUN_EN
   logic             active_start;
   logic             abandon;
`endif

   assign frame_end = (x == 10'd0) && (y == 10'(V_ACTIVE));
`ifdef FRAME_SEQ_OVERRUN_EN
   assign active_start = (x == 10'd0) && (y == 10'd0);
`endif

   assign angle_ext = {1'b0, angle};
   assign angle_inc = angle_ext + STEP_W;

   // wrapped candidate angle; 10-bit intermediates so nothing is lost before the wrap
   always_comb begin
      angle_calc = angle;
      if (!dir) begin
         if (angle_inc > MAX_W)
            angle_calc = 9'(angle_inc - MOD_W);
         else
            angle_calc = 9'(angle_inc);
      end else begin
         if (angle_ext < STEP_W)
            angle_calc = 9'(angle_ext + MOD_W - STEP_W);
         else
            angle_calc = 9'(angle_ext - STEP_W);
      end
   end

   // next-state and frame divider decode
   always_comb begin
      state_nx   = state;
      divider_nx = divider;
`ifdef FRAME_SEQ_OVERRUN_EN
      abandon    = 1'b0;
`endif
      case (state)
         WAIT_VBL: begin
            if (frame_end) begin
               if (run) begin
                  if (divider == DIV_LAST) begin
                     divider_nx = '0;
                     state_nx   = ADVANCE;
                  end else begin
                     divider_nx = divider + 1'b1;
                  end
               end else if (step_pending) begin
                  state_nx = ADVANCE;
               end
            end
         end
         ADVANCE:   state_nx = START;
         START:     state_nx = WAIT_DONE;
         WAIT_DONE: begin
            // a done arriving together with start of video still counts as done
            if (vs_done) begin
               state_nx = COMMIT;
            end
`ifdef FRAME_SEQ_OVERRUN_EN
            else if (active_start) begin
               state_nx = WAIT_VBL;
               abandon  = 1'b1;
            end
`endif
         end
         COMMIT:    state_nx = WAIT_VBL;
         default:   state_nx = WAIT_VBL;
      endcase
   end

   assign vs_start = (state == START);
   assign commit   = (state == COMMIT);
   assign busy     = (state != WAIT_VBL);

   // state register and divider
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state   <= WAIT_VBL;
         divider <= '0;
      end else begin
         state   <= state_nx;
         divider <= divider_nx;
      end
   end

   // single-step request, held until the advance that consumes it
   always_ff @(posedge clk_pix) begin
      if (rst)
         step_pending <= 1'b0;
      else if (state == ADVANCE)
         step_pending <= 1'b0;
      else if (step && !run)
         step_pending <= 1'b1;
   end

   // candidate and committed angle
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         angle_next <= '0;
         angle      <= '0;
      end else begin
         if (state == ADVANCE)
            angle_next <= angle_calc;
         if (state == COMMIT)
            angle <= angle_next;
`ifdef FRAME_SEQ_OVERRUN_EN
         if (abandon)
            angle_next <= angle;
`endif
      end
   end

   // frames since reset, counted regardless of state
   always_ff @(posedge clk_pix) begin
      if (rst)
         frame_count <= '0;
      else if (frame_end)
         frame_count <= frame_count + 16'd1;
   end

`ifdef FRAME_SEQ_OVERRUN_EN
   // abandoned jobs, saturating
   always_ff @(posedge clk_pix) begin
      if (rst)
         overrun_count <= '0;
      else if (abandon && (overrun_count != 8'hff))
         overrun_count <= overrun_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed bench with a commit scoreboard for frame_sequencer.
// Build with FRAME_SEQ_OVERRUN_EN defined to include the overrun scenario.
module tb_frame_sequencer;

   logic clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   logic        rst, run, step, dir;
   logic [9:0]  x, y;
   logic        resp_done, man_done, resp_done3;
   logic        vs_done, vs_done3;
   logic [8:0]  angle_next, angle, angle_next3, angle3;
   logic        vs_start, commit, busy, vs_start3, commit3, busy3;
   logic [15:0] frame_count, frame_count3;
`ifdef FRAME_SEQ_OVERRUN_EN
   logic [7:0]  overrun_count, overrun_count3;
`endif

   assign vs_done  = resp_done | man_done;
   assign vs_done3 = resp_done3;

   frame_sequencer #(.FRAME_DIV(1)) dut (
      .clk_pix(clk_pix), .rst(rst), .x(x), .y(y), .run(run), .step(step), .dir(dir),
      .angle_next(angle_next), .angle(angle), .vs_start(vs_start), .vs_done(vs_done),
      .commit(commit), .busy(busy), .frame_count(frame_count)
`ifdef FRAME_SEQ_OVERRUN_EN
      , .overrun_count(overrun_count)
`endif
   );

   frame_sequencer #(.FRAME_DIV(3)) dut3 (
      .clk_pix(clk_pix), .rst(rst), .x(x), .y(y), .run(run), .step(step), .dir(dir),
      .angle_next(angle_next3), .angle(angle3), .vs_start(vs_start3), .vs_done(vs_done3),
      .commit(commit3), .busy(busy3), .frame_count(frame_count3)
`ifdef FRAME_SEQ_OVERRUN_EN
      , .overrun_count(overrun_count3)
`endif
   );

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         fe_cycle = 0;
   int         commit_cnt = 0;
   int         commit3_cnt = 0;
   int         vs_start_cnt = 0;
   int         base, vbase, model;
   bit         auto_done = 1'b0;
   bit         lat_chk = 1'b0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_angle;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed=%0d required=%0d", tag, obs, req);
      end
   endtask

   always @(posedge clk_pix) cyc <= cyc + 1;

   // vert_shader model for the FRAME_DIV=1 instance: vs_done 5 cycles after vs_start
   initial begin
      resp_done = 1'b0;
      forever begin
         @(negedge clk_pix);
         if (vs_start && auto_done) begin
            repeat (5) @(negedge clk_pix);
            resp_done = 1'b1;
            @(negedge clk_pix);
            resp_done = 1'b0;
         end
      end
   end

   // vert_shader model for the FRAME_DIV=3 instance
   initial begin
      resp_done3 = 1'b0;
      forever begin
         @(negedge clk_pix);
         if (vs_start3 && auto_done) begin
            repeat (5) @(negedge clk_pix);
            resp_done3 = 1'b1;
            @(negedge clk_pix);
            resp_done3 = 1'b0;
         end
      end
   end

   // output monitor: start latency, commit scoreboard and commit latency
   always @(negedge clk_pix) begin
      if (!rst) begin
         if (commit3) commit3_cnt++;
         if (vs_start) begin
            vs_start_cnt++;
            chk("vs_start_latency", cyc - fe_cycle, 2);
         end
         if (commit) begin
            commit_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_commit: observed angle_next=%0d required no commit", angle_next);
            end
            if (exp_q.size() != 0) begin
               exp_angle = exp_q.pop_front();
               chk("commit_angle", angle_next, exp_angle);
               if (lat_chk) chk("commit_latency", cyc - fe_cycle, 8);
            end
         end
      end
   end

   task automatic frame(input int len);
      @(negedge clk_pix);
      x = 10'd0; y = 10'd480; fe_cycle = cyc;
      @(negedge clk_pix);
      x = 10'd5; y = 10'd5;
      repeat (len - 2) @(negedge clk_pix);
   endtask

   task automatic do_reset();
      @(negedge clk_pix);
      rst = 1'b1;
      @(negedge clk_pix);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic pulse_done();
      @(negedge clk_pix);
      man_done = 1'b1;
      @(negedge clk_pix);
      man_done = 1'b0;
      repeat (3) @(negedge clk_pix);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;
      x = 10'd5; y = 10'd5; man_done = 1'b0;
      auto_done = 1'b1; lat_chk = 1'b1;
      repeat (3) @(negedge clk_pix);
      chk("reset_angle", angle, 0);
      chk("reset_angle_next", angle_next, 0);
      chk("reset_busy", busy, 0);
      chk("reset_commit", commit, 0);
      chk("reset_vs_start", vs_start, 0);
      chk("reset_frame_count", frame_count, 0);
      chk("reset_busy3", busy3, 0);
      chk("reset_angle_next3", angle_next3, 0);
      rst = 1'b0;

      // FRAME_DIV=3 alongside FRAME_DIV=1
      run = 1'b1;
      for (int f = 1; f <= 9; f++) begin
         exp_q.push_back(9'(f));
         frame(16);
         if (f == 2) chk("div3_no_commit_f2", commit3_cnt, 0);
         if (f == 3) chk("div3_commit_f3", commit3_cnt, 1);
      end
      chk("div3_commits", commit3_cnt, 3);
      chk("div3_frame_count", frame_count3, 9);
      chk("div3_angle", angle3, 3);
      chk("div1_angle", angle, 9);
      chk("div1_frame_count", frame_count, 9);

      // full revolution and wrap 359 -> 0
      do_reset();
      model = 0;
      for (int f = 0; f < 360; f++) begin
         model = (model + 1) % 360;
         exp_q.push_back(9'(model));
         frame(16);
      end
      chk("wrap_angle", angle, 0);
      chk("wrap_angle_next", angle_next, 0);
      chk("wrap_frame_count", frame_count, 360);

      // decrement from reset wraps to 359
      do_reset();
      dir = 1'b1;
      exp_q.push_back(9'd359);
      frame(16);
      chk("dec_first", angle, 359);
      exp_q.push_back(9'd358);
      frame(16);
      chk("dec_second", angle, 358);
      run = 1'b0; dir = 1'b0;

      // two steps in one frame give one advance
      do_reset();
      base = commit_cnt;
      repeat (3) @(negedge clk_pix);
      step = 1'b1; @(negedge clk_pix); step = 1'b0;
      repeat (2) @(negedge clk_pix);
      step = 1'b1; @(negedge clk_pix); step = 1'b0;
      exp_q.push_back(9'd1);
      frame(16);
      chk("step_angle", angle, 1);
      repeat (4) frame(16);
      chk("step_single_commit", commit_cnt - base, 1);
      chk("step_angle_hold", angle, 1);
      // step while run=1 is not remembered
      run = 1'b1;
      @(negedge clk_pix); step = 1'b1; @(negedge clk_pix); step = 1'b0;
      run = 1'b0;
      frame(16);
      chk("step_ignored_run", commit_cnt - base, 1);

      // vs_done withheld across two further frames
      do_reset();
      run = 1'b1; auto_done = 1'b0; lat_chk = 1'b0;
      base = commit_cnt; vbase = vs_start_cnt;
      exp_q.push_back(9'd1);
      frame(16);
      chk("withheld_busy", busy, 1);
      frame(16);
      frame(16);
      chk("withheld_no_commit", commit_cnt - base, 0);
      chk("withheld_busy2", busy, 1);
      chk("withheld_frame_count", frame_count, 3);
      chk("withheld_one_start", vs_start_cnt - vbase, 1);
      run = 1'b0;
      pulse_done();
      chk("withheld_commit", commit_cnt - base, 1);
      chk("withheld_angle", angle, 1);
      chk("withheld_idle", busy, 0);

      // reset while waiting for vs_done
      do_reset();
      run = 1'b1; auto_done = 1'b1; lat_chk = 1'b1;
      for (int f = 1; f <= 7; f++) begin
         exp_q.push_back(9'(f));
         frame(16);
      end
      chk("pre_rst_angle", angle, 7);
      auto_done = 1'b0; lat_chk = 1'b0;
      frame(16);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk_pix);
      chk("rst_angle", angle, 0);
      chk("rst_angle_next", angle_next, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_count", frame_count, 0);
      rst = 1'b0; run = 1'b0;
      base = commit_cnt;
      pulse_done();
      chk("rst_no_commit", commit_cnt - base, 0);
      chk("rst_angle_hold", angle, 0);

`ifdef FRAME_SEQ_OVERRUN_EN
      // job still running at start of active video is abandoned
      do_reset();
      run = 1'b1;
      frame(16);
      run = 1'b0;
      chk("ovr_busy", busy, 1);
      @(negedge clk_pix); x = 10'd0; y = 10'd0;
      @(negedge clk_pix); x = 10'd5; y = 10'd5;
      @(negedge clk_pix);
      chk("ovr_count", overrun_count, 1);
      chk("ovr_angle", angle, 0);
      chk("ovr_angle_next", angle_next, 0);
      chk("ovr_idle", busy, 0);
      chk("ovr_count_div3", overrun_count3, 0);
      base = commit_cnt;
      pulse_done();
      chk("ovr_no_commit", commit_cnt - base, 0);
`endif

      repeat (2) @(negedge clk_pix);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
